// File: rtl/calc_tokens_pkg.sv
// Shared token codes, evaluated-word field positions and FSM state type
// for the calculator token path.
package calc_tokens_pkg;

  // Evaluated word layout: [41] is_num, [40] sign, [39:0] magnitude
  localparam int unsigned MAG_W      = 40;
  localparam int unsigned SIGN_BIT   = 40;
  localparam int unsigned IS_NUM_BIT = 41;

  // Key-token codes
  localparam logic [7:0] TOK_DIGIT0 = 8'd0;
  localparam logic [7:0] TOK_DIGIT1 = 8'd1;
  localparam logic [7:0] TOK_DIGIT2 = 8'd2;
  localparam logic [7:0] TOK_DIGIT3 = 8'd3;
  localparam logic [7:0] TOK_DIGIT4 = 8'd4;
  localparam logic [7:0] TOK_DIGIT5 = 8'd5;
  localparam logic [7:0] TOK_DIGIT6 = 8'd6;
  localparam logic [7:0] TOK_DIGIT7 = 8'd7;
  localparam logic [7:0] TOK_DIGIT8 = 8'd8;
  localparam logic [7:0] TOK_DIGIT9 = 8'd9;
  localparam logic [7:0] TOK_PLUS   = 8'd10;
  localparam logic [7:0] TOK_MINUS  = 8'd11;
  localparam logic [7:0] TOK_MUL    = 8'd12;
  localparam logic [7:0] TOK_DIV    = 8'd13;
  localparam logic [7:0] TOK_LPAREN = 8'd14;
  localparam logic [7:0] TOK_RPAREN = 8'd15;
  localparam logic [7:0] TOK_DOT    = 8'd16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT_OP,
    ST_CONVERT,
    ST_SCAN,
    ST_EMIT
  } state_e;

  // Double-dabble correction applied to a BCD nibble before each shift
  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one binary bit shifted in per cycle.
// done rises on the edge that completes the last shift and holds until
// the next start.
module bin2bcd_seq
  import calc_tokens_pkg::*;
#(
  parameter int unsigned BIN_W  = MAG_W,
  parameter int unsigned DIGITS = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned CW = $clog2(BIN_W) + 1;

  logic [BIN_W-1:0]    bin_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj_d;
  logic [CW-1:0]       cnt_q;
  logic                active_q;
  logic                done_q;

  // Add-3 correction on every nibble ahead of the shift
  always_comb begin
    adj_d = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      adj_d[4*d +: 4] = dd_adj(bcd_q[4*d +: 4]);
    end
  end

  // Load on start, then shift one magnitude bit per cycle for BIN_W cycles
  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      bin_q    <= bin;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b1;
      done_q   <= 1'b0;
    end else if (active_q) begin
      bcd_q <= {adj_d[4*DIGITS-2:0], bin_q[BIN_W-1]};
      bin_q <= {bin_q[BIN_W-2:0], 1'b0};
      if (cnt_q == CW'(BIN_W - 1)) begin
        active_q <= 1'b0;
        done_q   <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/num_to_tokens.sv
// Serialises one evaluated word (number or operator) into key-token codes
// with a valid/ready output handshake.
module num_to_tokens
  import calc_tokens_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NEWWIDTH    = 42,
  parameter int unsigned FRAC_DIGITS = 4,
  parameter int unsigned BCD_DIGITS  = 13
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NEWWIDTH-1:0] in_word,
  output logic                tok_valid,
  input  logic                tok_ready,
  output logic [WIDTH-1:0]    tok_data,
  output logic                tok_last,
  output logic                busy
);

  localparam int unsigned INT_DIGITS = BCD_DIGITS - FRAC_DIGITS;
  // Token positions: 0 '-', 1..INT_DIGITS integer digits (MS first),
  // INT_DIGITS+1 '.', then fraction digits (tenths first).
  localparam int unsigned PTR_MAX = INT_DIGITS + FRAC_DIGITS + 1;
  localparam int unsigned PW      = $clog2(PTR_MAX + 1);

  state_e               state_q;
  logic                 sign_q;
  logic                 tok_valid_q;
  logic                 tok_last_q;
  logic [WIDTH-1:0]     tok_data_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        first_q;
  logic [PW-1:0]        end_q;

  logic                 accept;
  logic                 bcd_start;
  logic                 bcd_done;
  logic [4*BCD_DIGITS-1:0] bcd;

  int unsigned          msd_k;
  int unsigned          frac_n;
  logic [PW-1:0]        scan_first;
  logic [PW-1:0]        scan_end;
  logic                 scan_neg;
  logic [PW-1:0]        ptr_d;
  logic [PW-1:0]        end_sel;
  logic [WIDTH-1:0]     tok_d;
  logic                 last_d;

  assign in_ready  = (state_q == ST_IDLE) && !reset;
  assign busy      = (state_q != ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign bcd_start = accept && in_word[IS_NUM_BIT];

  bin2bcd_seq #(
    .BIN_W  (MAG_W),
    .DIGITS (BCD_DIGITS)
  ) u_bcd (
    .clock (clock),
    .reset (reset),
    .start (bcd_start),
    .bin   (in_word[MAG_W-1:0]),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  function automatic logic [WIDTH-1:0] token_at(input logic [PW-1:0] p,
                                                input logic [4*BCD_DIGITS-1:0] b);
    int unsigned pi;
    logic [3:0]  n;
    pi       = 32'(p);
    n        = '0;
    token_at = '0;
    if (pi == 0) begin
      token_at = WIDTH'(TOK_MINUS);
    end else if (pi <= INT_DIGITS) begin
      n        = b[4*(BCD_DIGITS - pi) +: 4];
      token_at = WIDTH'(n);
    end else if (pi == INT_DIGITS + 1) begin
      token_at = WIDTH'(TOK_DOT);
    end else if (pi <= PTR_MAX) begin
      n        = b[4*(BCD_DIGITS + 1 - pi) +: 4];
      token_at = WIDTH'(n);
    end
  endfunction

  // Locate the first printed integer digit and the last printed fraction digit
  always_comb begin
    msd_k  = FRAC_DIGITS;
    frac_n = 0;
    for (int unsigned k = FRAC_DIGITS; k < BCD_DIGITS; k++) begin
      if (bcd[4*k +: 4] != 4'd0) msd_k = k;
    end
    for (int unsigned i = 0; i < FRAC_DIGITS; i++) begin
      if (bcd[4*(FRAC_DIGITS - 1 - i) +: 4] != 4'd0) frac_n = i + 1;
    end
    scan_first = PW'(BCD_DIGITS - msd_k);
    scan_end   = (frac_n == 0) ? PW'(INT_DIGITS) : PW'(INT_DIGITS + 1 + frac_n);
    scan_neg   = sign_q && (bcd != '0);
  end

  // Next token position and its code; '-' jumps straight to the first digit
  always_comb begin
    if (state_q == ST_SCAN) begin
      ptr_d   = scan_neg ? '0 : scan_first;
      end_sel = scan_end;
    end else begin
      ptr_d   = (ptr_q == '0) ? first_q : ptr_q + 1'b1;
      end_sel = end_q;
    end
    tok_d  = token_at(ptr_d, bcd);
    last_d = (ptr_d == end_sel);
  end

  // Control FSM with registered token outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      tok_valid_q <= 1'b0;
      tok_last_q  <= 1'b0;
      tok_data_q  <= '0;
      ptr_q       <= '0;
      first_q     <= '0;
      end_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sign_q <= in_word[SIGN_BIT];
            if (in_word[IS_NUM_BIT]) begin
              state_q <= ST_CONVERT;
            end else begin
              state_q     <= ST_EMIT_OP;
              tok_valid_q <= 1'b1;
              tok_data_q  <= in_word[WIDTH-1:0];
              tok_last_q  <= 1'b1;
            end
          end
        end
        ST_EMIT_OP: begin
          if (tok_ready) begin
            state_q     <= ST_IDLE;
            tok_valid_q <= 1'b0;
            tok_last_q  <= 1'b0;
          end
        end
        ST_CONVERT: begin
          if (bcd_done) state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          state_q     <= ST_EMIT;
          first_q     <= scan_first;
          end_q       <= scan_end;
          ptr_q       <= ptr_d;
          tok_valid_q <= 1'b1;
          tok_data_q  <= tok_d;
          tok_last_q  <= last_d;
        end
        ST_EMIT: begin
          if (tok_ready) begin
            if (tok_last_q) begin
              state_q     <= ST_IDLE;
              tok_valid_q <= 1'b0;
              tok_last_q  <= 1'b0;
            end else begin
              ptr_q      <= ptr_d;
              tok_data_q <= tok_d;
              tok_last_q <= last_d;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tok_valid = tok_valid_q;
  assign tok_data  = tok_data_q;
  assign tok_last  = tok_last_q;

endmodule
